// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIXUP,
    S_DONE
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_high(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic bit cfg_ok(input int xlen, input int step);
    return (step == 1 || step == 2 || step == 4) && (xlen % step == 0) && (xlen >= 8);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= (XLEN+2)'(divisor));
  assign rem_out = q_bit ? (XLEN+1)'(shifted - (XLEN+2)'(divisor)) : (XLEN+1)'(shifted);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one-cycle done strobe.
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | iterating (multiply digits or quotient bits)
//   FIXUP  | sign correction and result selection
//   DONE   | result presented, done strobe high
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  if (!cfg_ok(XLEN, MUL_STEP)) begin : g_bad_cfg
    $error("muldiv_unit: XLEN must be >= 8 and a multiple of MUL_STEP, MUL_STEP in {1,2,4}");
  end

  muldiv_state_e     state;
  muldiv_op_e        op;
  logic [XLEN-1:0]   mag_a, mag_b, quo;
  logic              sgn_a, sgn_b;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [CW-1:0]     cnt;

  muldiv_op_e      op_in;
  logic            neg_a_in, neg_b_in, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  assign op_in    = muldiv_op_e'(funct3);
  assign neg_a_in = is_signed_a(op_in) & a[XLEN-1];
  assign neg_b_in = is_signed_b(op_in) & b[XLEN-1];
  assign abs_a    = neg_a_in ? -a : a;
  assign abs_b    = neg_b_in ? -b : b;
  assign div_zero = is_div(op_in) && (b == '0);
  assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (a == MIN_INT) && (b == '1);

  // Special divides resolve in IDLE; signed-overflow REM falls through to zero.
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : a;
    else if (op_in == OP_DIV)
      special_res = a;
  end

  logic [MUL_STEP-1:0]      mul_digit;
  logic [XLEN+MUL_STEP-1:0] mul_sum;
  logic [2*XLEN-1:0]        acc_next;

  // Upper half never exceeds 2^XLEN-1, so the sum fits XLEN+MUL_STEP bits.
  assign mul_digit = acc[MUL_STEP-1:0];
  assign mul_sum   = (XLEN+MUL_STEP)'(acc[2*XLEN-1:XLEN])
                   + (XLEN+MUL_STEP)'(mag_a) * (XLEN+MUL_STEP)'(mul_digit);
  assign acc_next  = {mul_sum, acc[XLEN-1:MUL_STEP]};

  logic [XLEN:0] rem_next;
  logic          q_bit;

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem),
    .bit_in  (quo[XLEN-1]),
    .divisor (mag_b),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  logic [2*XLEN-1:0] prod_f;
  logic [XLEN-1:0]   quo_f, rem_f, fix_res;

  assign prod_f = (sgn_a ^ sgn_b) ? -acc : acc;
  assign quo_f  = (sgn_a ^ sgn_b) ? -quo : quo;
  assign rem_f  = sgn_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];

  always_comb begin
    fix_res = prod_f[XLEN-1:0];
    if (is_div(op))
      fix_res = op[1] ? rem_f : quo_f;
    else if (is_high(op))
      fix_res = prod_f[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op     <= OP_MUL;
      mag_a  <= '0;
      mag_b  <= '0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !kill) begin
            op    <= op_in;
            mag_a <= abs_a;
            mag_b <= abs_b;
            sgn_a <= neg_a_in;
            sgn_b <= neg_b_in;
            acc   <= {{XLEN{1'b0}}, abs_b};
            rem   <= '0;
            quo   <= abs_a;
            cnt   <= is_div(op_in) ? DIV_LAST : MUL_LAST;
            if (div_zero || div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (is_div(op)) begin
              rem <= rem_next;
              quo <= {quo[XLEN-2:0], q_bit};
            end else begin
              acc <= acc_next;
            end
            if (cnt == '0) state <= S_FIXUP;
            else           cnt   <= cnt - 1'b1;
          end
        end
        S_FIXUP: begin
          busy <= 1'b0;
          if (kill) begin
            state <= S_IDLE;
          end else begin
            result <= fix_res;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic model plus cycle-exact busy/done/result tracking.
import muldiv_pkg::*;

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic        start4, busy4, done4;
  logic [31:0] result4;
  logic        start2, busy2, done2;
  logic [31:0] result2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Scoreboard state for the default-parameter DUT
  bit          active = 1'b0;
  int          t_start = 0;
  int          lat = 0;
  int          t_kill = -1;
  logic [31:0] held_res = '0;
  logic [31:0] new_res = '0;

  muldiv_unit u_dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  muldiv_unit #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .busy(busy4), .done(done4), .result(result4)
  );

  muldiv_unit #(.XLEN(32), .MUL_STEP(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .busy(busy2), .done(done2), .result(result2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    longint      uy = longint'({32'b0, y});
    logic [63:0] p;
    bit          ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = 64'(sx * sy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'd0 : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && (y == 0 || ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
      return 1;
    return f[2] ? 32 + 2 : 32 / 1 + 2;
  endfunction

  // Per-cycle compare of the default DUT against the scoreboard
  always @(negedge clk) begin
    logic        eb, ed;
    logic [31:0] er;
    int          k;
    k = cyc - t_start;
    if (reset) begin
      eb = 1'b0; ed = 1'b0; er = '0;
    end else if (!active || (t_kill >= 0 && cyc > t_kill)) begin
      eb = 1'b0; ed = 1'b0; er = held_res;
    end else begin
      eb = (k >= 1) && (k < lat);
      ed = (k == lat);
      er = (k >= lat) ? new_res : held_res;
    end
    check("busy", busy, eb);
    check("done", done, ed);
    check("result", result, er);
  end

  // mode 0: plain; 1: start held into the DONE cycle; 2: kill in the DONE cycle
  task automatic run_op(input logic [2:0] f, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] lit, input int mode);
    @(posedge clk); #1;
    funct3 = f; a = va; b = vb; start = 1'b1;
    t_start = cyc; lat = model_lat(f, va, vb); new_res = model(f, va, vb);
    t_kill = -1; active = 1'b1;
    check("model_pin", new_res, lit);
    @(posedge clk); #1;
    start = (mode == 1);
    kill  = (mode == 2);
    if (mode == 2) t_kill = cyc;
    repeat (lat - 1) begin
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
    end
    @(negedge clk);
    check("literal_result", result, lit);
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    held_res = new_res; active = 1'b0;
  endtask

  task automatic run_step(input int which, input int exp_lat);
    int  c;
    bit  found;
    @(posedge clk); #1;
    funct3 = OP_MUL; a = 32'h0001_0001; b = 32'h0003_0003;
    if (which == 4) start4 = 1'b1; else start2 = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    start4 = 1'b0; start2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if ((which == 4) ? done4 : done2) begin
        found = 1'b1;
        check("step_latency", 64'(cyc - c), 64'(exp_lat));
        check("step_result", (which == 4) ? result4 : result2, 32'h0006_0003);
        check("step_model", (which == 4) ? result4 : result2, model(OP_MUL, a, b));
      end else begin
        check("step_busy", (which == 4) ? busy4 : busy2, 1'b1);
      end
    end
    if (!found) check("step_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; a = '0; b = '0;
    start4 = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);

    run_op(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0);
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0);
    run_op(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0);
    run_op(OP_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 0);
    run_op(OP_REMU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 0);
    run_op(OP_DIVU,   32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    run_op(OP_REMU,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 2);
    run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(OP_DIV,    32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0);
    run_op(OP_REM,    32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(OP_DIVU,   32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 0);
    run_op(OP_REMU,   32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 0);

    // Kill mid-multiply at c+10, restart at c+12
    @(posedge clk); #1;
    funct3 = OP_MUL; a = 32'd5; b = 32'd6; start = 1'b1;
    t_start = cyc; lat = model_lat(OP_MUL, a, b); new_res = model(OP_MUL, a, b);
    t_kill = -1; active = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    kill = 1'b1; t_kill = cyc;
    @(posedge clk); #1;
    kill = 1'b0; active = 1'b0;
    run_op(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 0);

    // start with kill in IDLE must be ignored
    @(posedge clk); #1;
    funct3 = OP_DIVU; a = 32'd9; b = 32'd0; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    repeat (3) @(posedge clk);

    run_step(4, 10);
    run_step(2, 18);

    // Reset mid-multiply at c+5
    @(posedge clk); #1;
    funct3 = OP_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
    t_start = cyc; lat = model_lat(OP_MUL, a, b); new_res = model(OP_MUL, a, b);
    t_kill = -1; active = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1; active = 1'b0; held_res = '0;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_op(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
